// File: rtl/usb_serial_pkg.sv
// Shared register map, status layout and helpers for the USB serial FIFO bridge.
package usb_serial_pkg;

    // Register byte offsets (addr_i[1:0] ignored)
    localparam logic [3:0] CTRL_OFS = 4'd0;
    localparam logic [3:0] RDR_OFS  = 4'd4;
    localparam logic [3:0] TDR_OFS  = 4'd8;
    localparam logic [3:0] STA_OFS  = 4'd12;

    // Word select decoded from addr_i[3:2]
    typedef enum logic [1:0] {
        REG_CTRL = 2'd0,
        REG_RDR  = 2'd1,
        REG_TDR  = 2'd2,
        REG_STA  = 2'd3
    } reg_sel_e;

    // CTRL flush bits
    localparam int CTRL_TX_FLUSH = 0;
    localparam int CTRL_RX_FLUSH = 1;

    // STA bit indices
    localparam int STA_TX_FULL     = 0;
    localparam int STA_RX_NONEMPTY = 1;
    localparam int STA_TX_EMPTY    = 2;
    localparam int STA_RX_OVF      = 3;
    localparam int STA_TX_OVF      = 4;

    // STA word layout, MSB first; matches the bit indices above
    typedef struct packed {
        logic [7:0] rsvd_hi;
        logic [7:0] rx_count;
        logic [7:0] tx_count;
        logic [2:0] rsvd_lo;
        logic       tx_ovf;
        logic       rx_ovf;
        logic       tx_empty;
        logic       rx_nonempty;
        logic       tx_full;
    } sta_t;

    // Counts of 256 do not fit in 8 bits; report them as 255
    function automatic logic [7:0] sat_cnt8(input logic [8:0] c);
        return c[8] ? 8'hFF : c[7:0];
    endfunction

endpackage

// File: rtl/usb_byte_fifo.sv
// Byte FIFO with first-word fall-through head, flush and overflow pulse.
module usb_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [7:0]    data_i,
    input  logic          pop_i,
    output logic [7:0]    head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o,
    output logic          ovf_o
);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wptr, rptr;
    logic        do_pop, do_push;

    assign empty_o = (wptr == rptr);
    assign full_o  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count_o = wptr - rptr;

    // A pop frees a slot in the same cycle, so push into a full FIFO is legal then
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && (!full_o || do_pop) && !flush_i;
    assign ovf_o   = push_i && full_o && !do_pop && !flush_i;

    // Storage is unreset, so the head is masked while nothing valid is held
    assign head_o  = empty_o ? 8'h00 : mem[rptr[AW-1:0]];

    // Pointer update; flush dominates any push/pop in the same cycle
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush_i) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // Data storage write
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/usb_serial_fifo.sv
// CPU register front-end with TX/RX byte FIFOs toward the USB CDC core.
module usb_serial_fifo
    import usb_serial_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        bus_wr_i,
    input  logic        bus_rd_i,
    input  logic [3:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic [7:0]  send_data_o,
    output logic        send_valid_o,
    input  logic        send_ready_i,
    input  logic [7:0]  recv_data_i,
    input  logic        recv_valid_i
);

    reg_sel_e    sel;
    logic        wr_ctrl, wr_tdr, wr_sta, rd_rdr;
    logic        tx_flush, rx_flush;
    logic [7:0]  tx_head, rx_head;
    logic        tx_full, tx_empty, rx_full, rx_empty;
    logic [AW:0] tx_count, rx_count;
    logic        tx_ovf_pulse, rx_ovf_pulse;
    logic        tx_ovf, rx_ovf;
    sta_t        sta;
    logic        unused_bits;

    assign sel     = reg_sel_e'(addr_i[3:2]);
    assign wr_ctrl = bus_wr_i && (sel == REG_CTRL);
    assign wr_tdr  = bus_wr_i && (sel == REG_TDR);
    assign wr_sta  = bus_wr_i && (sel == REG_STA);
    assign rd_rdr  = bus_rd_i && (sel == REG_RDR);

    assign tx_flush = wr_ctrl && wdata_i[CTRL_TX_FLUSH];
    assign rx_flush = wr_ctrl && wdata_i[CTRL_RX_FLUSH];

    assign unused_bits = ^{addr_i[1:0], wdata_i[31:8], rx_full};

    usb_byte_fifo #(.DEPTH(DEPTH), .AW(AW)) u_tx (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .flush_i (tx_flush),
        .push_i  (wr_tdr),
        .data_i  (wdata_i[7:0]),
        .pop_i   (send_valid_o && send_ready_i),
        .head_o  (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .count_o (tx_count),
        .ovf_o   (tx_ovf_pulse)
    );

    usb_byte_fifo #(.DEPTH(DEPTH), .AW(AW)) u_rx (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .flush_i (rx_flush),
        .push_i  (recv_valid_i),
        .data_i  (recv_data_i),
        .pop_i   (rd_rdr),
        .head_o  (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .count_o (rx_count),
        .ovf_o   (rx_ovf_pulse)
    );

    assign send_valid_o = !tx_empty;
    assign send_data_o  = tx_head;

    // Status word as seen by a read this cycle
    always_comb begin
        sta             = '0;
        sta.tx_full     = tx_full;
        sta.rx_nonempty = !rx_empty;
        sta.tx_empty    = tx_empty;
        sta.rx_ovf      = rx_ovf;
        sta.tx_ovf      = tx_ovf;
        sta.tx_count    = sat_cnt8(9'(tx_count));
        sta.rx_count    = sat_cnt8(9'(rx_count));
    end

    // Sticky overflow flags: flush clears, new overflow beats a W1C clear
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tx_ovf <= 1'b0;
            rx_ovf <= 1'b0;
        end else begin
            if (tx_flush)                            tx_ovf <= 1'b0;
            else if (tx_ovf_pulse)                   tx_ovf <= 1'b1;
            else if (wr_sta && wdata_i[STA_TX_OVF])  tx_ovf <= 1'b0;

            if (rx_flush)                            rx_ovf <= 1'b0;
            else if (rx_ovf_pulse)                   rx_ovf <= 1'b1;
            else if (wr_sta && wdata_i[STA_RX_OVF])  rx_ovf <= 1'b0;
        end
    end

    // Registered read data; holds between reads
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rdata_o <= '0;
        end else if (bus_rd_i) begin
            case (sel)
                REG_RDR: rdata_o <= {24'b0, rx_head};
                REG_STA: rdata_o <= sta;
                default: rdata_o <= '0;
            endcase
        end
    end

endmodule
